// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and constants for freq_ratio_meter.
//   meter_state_t : measurement FSM states
//   CNT_W_DEF     : default counter width
//   cnt_sat()     : all-ones saturation value for a counter of width w (w <= 32)
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } meter_state_t;

    localparam int CNT_W_DEF = 16;

    // 2^w - 1; the 32-bit wrap makes w == 32 come out as all ones too.
    function automatic logic [31:0] cnt_sat(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/freq_ratio_meter_edge_sync.sv
// edge_sync: conditions the measured signal and detects its rising edge.
// Optional build macro: FREQ_METER_SYNC_EN adds a two-flop synchronizer in
// front of sig_s so SIG_IN may be asynchronous to CLK_IN (+2 cycles latency).
// Ports:
//   CLK_IN  in   reference clock
//   RST     in   synchronous active-high reset
//   SIG_IN  in   raw signal under measurement
//   sig_s   out  conditioned signal
//   rise    out  sig_s rising edge (sig_s & ~sig_d)
module edge_sync (
    input  logic CLK_IN,
    input  logic RST,
    input  logic SIG_IN,
    output logic sig_s,
    output logic rise
);

    logic sig_d;

`ifdef FREQ_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK_IN) begin
        if (RST) sync_q <= '0;
        else     sync_q <= {sync_q[0], SIG_IN};
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = SIG_IN;
`endif

    always_ff @(posedge CLK_IN) begin
        if (RST) sig_d <= 1'b0;
        else     sig_d <= sig_s;
    end

    assign rise = sig_s & ~sig_d;

endmodule

// File: rtl/freq_ratio_meter.sv
// freq_ratio_meter: measures period and high time of a slow divided clock in
// CLK_IN cycles, and reports lock (two equal consecutive periods) and a sticky
// loss-of-signal timeout. Build macro FREQ_METER_SYNC_EN (see edge_sync).
// Ports:
//   CLK_IN      in   reference clock
//   RST         in   synchronous active-high reset
//   EN          in   measurement enable, low forces IDLE
//   SIG_IN      in   signal under measurement
//   PERIOD      out  cycles between consecutive rising edges
//   HIGH_TIME   out  cycles high within that period
//   MEAS_VALID  out  one-cycle pulse when PERIOD/HIGH_TIME update
//   LOCKED      out  last two measured periods equal
//   TIMEOUT     out  no edge for 2^CNT_W-1 cycles, sticky until next edge
module freq_ratio_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             EN,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic             MEAS_VALID,
    output logic             LOCKED,
    output logic             TIMEOUT
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    meter_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic             prev_valid;
    logic             sig_s;
    logic             rise;

    edge_sync u_edge (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .SIG_IN (SIG_IN),
        .sig_s  (sig_s),
        .rise   (rise)
    );

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            prev_valid <= 1'b0;
            PERIOD     <= '0;
            HIGH_TIME  <= '0;
            MEAS_VALID <= 1'b0;
            LOCKED     <= 1'b0;
            TIMEOUT    <= 1'b0;
        end else if (!EN) begin
            // PERIOD/HIGH_TIME deliberately keep the last measurement
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            prev_valid <= 1'b0;
            MEAS_VALID <= 1'b0;
            LOCKED     <= 1'b0;
            TIMEOUT    <= 1'b0;
        end else begin
            MEAS_VALID <= 1'b0;
            unique case (state)
                IDLE: state <= WAIT_EDGE;
                WAIT_EDGE: begin
                    if (rise) begin
                        cnt     <= CNT_ONE;
                        hcnt    <= CNT_ONE;
                        TIMEOUT <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    // a rise wins over saturation in the same cycle
                    if (rise) begin
                        PERIOD     <= cnt;
                        HIGH_TIME  <= hcnt;
                        MEAS_VALID <= 1'b1;
                        LOCKED     <= prev_valid && (cnt == PERIOD);
                        prev_valid <= 1'b1;
                        TIMEOUT    <= 1'b0;
                        cnt        <= CNT_ONE;
                        hcnt       <= CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        // lost signal: need two fresh edges before next result
                        TIMEOUT    <= 1'b1;
                        LOCKED     <= 1'b0;
                        prev_valid <= 1'b0;
                        state      <= WAIT_EDGE;
                    end else begin
                        cnt  <= cnt + CNT_ONE;
                        hcnt <= hcnt + {{(CNT_W-1){1'b0}}, sig_s};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_ratio_meter.sv
module tb_freq_ratio_meter;

    localparam int CNT_W = 8;
    localparam int SAT   = 255;
`ifdef FREQ_METER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             CLK_IN = 1'b0;
    logic             RST    = 1'b1;
    logic             EN     = 1'b0;
    logic             SIG_IN = 1'b0;
    logic [CNT_W-1:0] PERIOD;
    logic [CNT_W-1:0] HIGH_TIME;
    logic             MEAS_VALID;
    logic             LOCKED;
    logic             TIMEOUT;

    freq_ratio_meter #(.CNT_W(CNT_W)) dut (
        .CLK_IN     (CLK_IN),
        .RST        (RST),
        .EN         (EN),
        .SIG_IN     (SIG_IN),
        .PERIOD     (PERIOD),
        .HIGH_TIME  (HIGH_TIME),
        .MEAS_VALID (MEAS_VALID),
        .LOCKED     (LOCKED),
        .TIMEOUT    (TIMEOUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int cyc = 0;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard entry: expected result and the cycle it must appear in
    typedef struct {
        int period;
        int high;
        bit locked;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    // reference model in terms of rise timestamps of the driven samples
    bit mdl_act   = 1'b0;
    bit prev_s    = 1'b0;
    bit have_rise = 1'b0;
    bit have_prev = 1'b0;
    int last_n    = 0;
    int prev_per  = 0;
    int hc        = 0;

    task automatic mdl_clear();
        mdl_act   = 1'b0;
        have_rise = 1'b0;
        have_prev = 1'b0;
    endtask

    task automatic model(input bit s, input int n);
        exp_t e;
        if (mdl_act) begin
            if (s && !prev_s) begin
                if (have_rise) begin
                    e.period = n - last_n;
                    e.high   = hc;
                    e.locked = have_prev && ((n - last_n) == prev_per);
                    e.cyc    = n + LAT;
                    exp_q.push_back(e);
                    prev_per  = n - last_n;
                    have_prev = 1'b1;
                end
                have_rise = 1'b1;
                last_n    = n;
                hc        = 1;
            end else if (have_rise) begin
                if ((n - last_n) == SAT) begin
                    have_rise = 1'b0;
                    have_prev = 1'b0;
                end else begin
                    hc += int'(s);
                end
            end
        end
        prev_s = s;
    endtask

    task automatic drv(input bit s);
        @(posedge CLK_IN);
        #1;
        SIG_IN = s;
        model(s, cyc);
    endtask

    task automatic wave(input int hi, input int lo, input int nper);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < hi; i++) drv(1'b1);
            for (int i = 0; i < lo; i++) drv(1'b0);
        end
    endtask

    // one rise, then hold lvl until timeout; checks exact assertion cycle
    task automatic to_run(input bit lvl, input string tag, input bit lock_pre);
        int n;
        drv(1'b1);
        n = cyc;
        while (cyc < n + LAT + SAT - 1) drv(lvl);
        @(negedge CLK_IN);
        chk({tag, "_to_pre"}, 32'(TIMEOUT), 0);
        chk({tag, "_lock_pre"}, 32'(LOCKED), 32'(lock_pre));
        drv(lvl);
        @(negedge CLK_IN);
        chk({tag, "_to_set"}, 32'(TIMEOUT), 1);
        chk({tag, "_lock_clr"}, 32'(LOCKED), 0);
        repeat (5) drv(lvl);
        @(negedge CLK_IN);
        chk({tag, "_to_sticky"}, 32'(TIMEOUT), 1);
    endtask

    // monitor: every cycle MEAS_VALID must match the scoreboard
    always @(negedge CLK_IN) begin
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("mv_pulse", 32'(MEAS_VALID), 1);
            chk("period", 32'(PERIOD), e.period);
            chk("high_time", 32'(HIGH_TIME), e.high);
            chk("locked", 32'(LOCKED), 32'(e.locked));
        end else begin
            chk("mv_quiet", 32'(MEAS_VALID), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n2;
        // reset state
        repeat (3) drv(1'b0);
        @(negedge CLK_IN);
        chk("rst_period", 32'(PERIOD), 0);
        chk("rst_high", 32'(HIGH_TIME), 0);
        chk("rst_mv", 32'(MEAS_VALID), 0);
        chk("rst_locked", 32'(LOCKED), 0);
        chk("rst_timeout", 32'(TIMEOUT), 0);
        RST = 1'b0;
        EN  = 1'b1;
        mdl_act = 1'b1;
        repeat (3) drv(1'b0);

        // divide-by-5 reference, then 10 -> 12 period change, then 1-in-7 pulse
        wave(5, 5, 5);
        wave(6, 6, 3);
        wave(1, 6, 4);

        // constant low after a rise -> timeout, then recovery
        to_run(1'b0, "low", 1'b1);
        repeat (3) drv(1'b0);
        drv(1'b1);
        n2 = cyc;
        while (cyc < n2 + LAT - 1) drv(1'b0);
        @(negedge CLK_IN);
        chk("low_to_hold", 32'(TIMEOUT), 1);
        drv(1'b0);
        @(negedge CLK_IN);
        chk("low_to_clr", 32'(TIMEOUT), 0);
        repeat (4) drv(1'b0);
        wave(5, 5, 3);

        // constant high -> timeout
        to_run(1'b1, "high", 1'b1);
        repeat (5) drv(1'b0);
        wave(5, 5, 4);

        // RST mid-period: outputs return to reset values
        repeat (4) drv(1'b1);
        RST = 1'b1;
        mdl_clear();
        drv(1'b1);
        repeat (4) drv(1'b0);
        @(negedge CLK_IN);
        chk("mrst_period", 32'(PERIOD), 0);
        chk("mrst_high", 32'(HIGH_TIME), 0);
        chk("mrst_mv", 32'(MEAS_VALID), 0);
        chk("mrst_locked", 32'(LOCKED), 0);
        chk("mrst_timeout", 32'(TIMEOUT), 0);
        RST = 1'b0;
        mdl_act = 1'b1;
        repeat (3) drv(1'b0);
        wave(5, 5, 3);

        // EN=0 mid-period: results hold, status clears
        repeat (4) drv(1'b1);
        EN = 1'b0;
        mdl_clear();
        drv(1'b1);
        repeat (4) drv(1'b0);
        @(negedge CLK_IN);
        chk("en0_period", 32'(PERIOD), 10);
        chk("en0_high", 32'(HIGH_TIME), 5);
        chk("en0_mv", 32'(MEAS_VALID), 0);
        chk("en0_locked", 32'(LOCKED), 0);
        chk("en0_timeout", 32'(TIMEOUT), 0);
        EN = 1'b1;
        mdl_act = 1'b1;
        repeat (3) drv(1'b0);
        wave(6, 4, 3);

        repeat (6) drv(1'b0);
        @(negedge CLK_IN);
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/freq_ratio_meter.md
# freq_ratio_meter

Measures the period and high time of a slow, divider-generated signal in units of the fast reference clock CLK_IN. It is the receiving end of the divider blocks: it checks a divided clock such as a divide-by-5 output and reports the measured ratio, duty, lock and loss-of-signal status to control/debug logic.

## Interface
- CNT_W, 16, width of the period/high-time counters and outputs (≥4)
- CLK_IN  input  1  reference clock; all logic on posedge
- RST  input  1  reset; synchronous, active-high
- EN  input  1  measurement enable; low forces IDLE
- SIG_IN  input  1  signal under measurement (divided clock)
- PERIOD  output  CNT_W  CLK_IN cycles between consecutive SIG_IN rising edges
- HIGH_TIME  output  CNT_W  CLK_IN cycles SIG_IN was high within that period
- MEAS_VALID  output  1  one-cycle pulse when PERIOD/HIGH_TIME update
- LOCKED  output  1  the last two measured periods are equal
- TIMEOUT  output  1  no rising edge seen for 2^CNT_W−1 cycles; sticky

## Operation
- The edge front end produces sig_s (the conditioned SIG_IN) and sig_d (sig_s delayed one cycle). rise = sig_s & ~sig_d.
- States: IDLE, WAIT_EDGE, MEASURE.
- IDLE:
  - Entered on RST or EN=0.
  - cnt and hcnt are 0, and prev_valid is 0.
  - LOCKED=0, TIMEOUT=0, MEAS_VALID=0.
  - PERIOD and HIGH_TIME hold their last values.
  - EN=1 moves to WAIT_EDGE.
- WAIT_EDGE: on rise, set cnt=1 and hcnt=1, then go to MEASURE.
- MEASURE, each cycle:
  - On rise:
    - PERIOD<=cnt, HIGH_TIME<=hcnt, MEAS_VALID<=1.
    - LOCKED<=(prev_valid && cnt==PERIOD).
    - prev_valid<=1, TIMEOUT<=0.
    - cnt<=1, hcnt<=1.
  - Otherwise: cnt<=cnt+1 and hcnt<=hcnt+sig_s.
- hcnt never exceeds cnt. All arithmetic is unsigned at CNT_W bits.
- Timeout: in MEASURE with no rise and cnt==2^CNT_W−1, the block sets TIMEOUT=1, LOCKED=0 and prev_valid=0, then goes to WAIT_EDGE. TIMEOUT stays set until the next rise or until EN=0 or RST.
- Simultaneous events:
  - RST overrides everything.
  - EN=0 overrides rise and timeout.
  - A rise in the same cycle as cnt saturation counts as a rise, not a timeout.
- Reset mid-measurement: the partial count is discarded. The next measurement needs two fresh edges.
- A single-cycle-high SIG_IN is measured correctly, giving HIGH_TIME=1. Constant-high and constant-low inputs both end in timeout.

## Timing
- Reset values: PERIOD=0, HIGH_TIME=0, MEAS_VALID=0, LOCKED=0, TIMEOUT=0, state IDLE.
- Latency is measured from the SIG_IN rising edge sampled at CLK_IN edge k to MEAS_VALID: cycle k+1 without the macro, k+3 with it.
- PERIOD, HIGH_TIME and LOCKED are valid in the same cycle as MEAS_VALID and hold until the next pulse.
- TIMEOUT asserts in the cycle after the cycle in which cnt reached 2^CNT_W−1.
- Reference: a divide-by-5 source has a 10-cycle period. It yields PERIOD=10, HIGH_TIME=5, with MEAS_VALID every 10 cycles.

## Configuration
- Macro: FREQ_METER_SYNC_EN.
- Defined:
  - SIG_IN passes through a two-flop synchronizer before sig_s, so it may be fully asynchronous to CLK_IN.
  - Adds 2 cycles of latency. Measured values are unchanged.
- Undefined:
  - sig_s = SIG_IN directly, so SIG_IN must be synchronous to CLK_IN.
  - Only the sig_d flop exists.

## Structure
- Package freq_meter_pkg holds:
  - the state enum type (IDLE, WAIT_EDGE, MEASURE);
  - the default CNT_W constant;
  - a function returning the saturation value for a given width.
- Sub-module edge_sync contains the optional synchronizer, the sig_d flop, and the sig_s/rise outputs. The FREQ_METER_SYNC_EN logic lives there.
- The FSM, counters and output registers live in freq_ratio_meter.

## Test plan
- Divide-by-5 model driving SIG_IN, EN=1:
  - The first MEAS_VALID reports PERIOD=10 and HIGH_TIME=5 with LOCKED=0.
  - The second MEAS_VALID has LOCKED=1.
  - Pulses arrive every 10 cycles.
- Period change from 10 to 12 (high 6) after lock: the first pulse at 12 gives LOCKED=0, and the next gives LOCKED=1.
- CNT_W=8, SIG_IN held low after a rise:
  - TIMEOUT=1 and LOCKED=0 after 255 cycles without an edge.
  - The next rise clears TIMEOUT with no MEAS_VALID.
  - The following rise gives a valid PERIOD.
- SIG_IN high for 1 cycle every 7 cycles: PERIOD=7 and HIGH_TIME=1.
- RST, then separately EN=0, asserted mid-period:
  - All outputs are at reset or hold values as specified.
  - No MEAS_VALID appears until two rises after release.
  - The first measured period is exact.
- Compare runs with and without FREQ_METER_SYNC_EN: PERIOD and HIGH_TIME are identical, and MEAS_VALID occurs exactly 2 cycles later with the macro.
